chroma_calib_ctrl: RTL

Calibration and configuration controller for the chroma-key pixel path. On request it samples the key colour from a fixed 16x16 window in the live camera frame, averages it, and derives the green and difference thresholds. It also accepts manual threshold writes. New thresholds are shadowed and take effect only at start of frame, so no frame is keyed with mixed settings. Sits beside the keyer, fed by the same pixel/x/y/DE stream, driving its threshold inputs.

---
 rtl/chroma_pkg.sv | 21 ++
 rtl/chroma_win_accum.sv | 75 +++++++
 rtl/chroma_calib_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/chroma_pkg.sv
// Shared types and constants for the chroma-key calibration path.
// The keyer imports DEF_G / DEF_DIFF so both blocks agree on the power-up thresholds.
package chroma_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACCUM    = 2'd2,
    COMPUTE  = 2'd3
  } calib_state_e;

  localparam int WIN_SIZE = 16;
  localparam int WIN_LOG2 = 4;
  // 256 samples of 4 bits never exceed 12 bits, so the sums cannot wrap.
  localparam int ACC_W    = 2 * WIN_LOG2 + 4;
  localparam int CNT_W    = 2 * WIN_LOG2 + 1;

  localparam logic [3:0] DEF_G    = 4'd10;
  localparam logic [3:0] DEF_DIFF = 4'd4;

endpackage

// File: rtl/chroma_win_accum.sv
// Sums r/g/b over the fixed 16x16 sampling window and counts the samples taken.
// Accumulation stops by itself once all 256 window pixels have been seen.
module chroma_win_accum
  import chroma_pkg::*;
#(
  parameter logic [9:0] WIN_X0 = 10'd312,
  parameter logic [9:0] WIN_Y0 = 10'd232
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             de_i,
  input  logic [9:0]       x_i,
  input  logic [9:0]       y_i,
  input  logic [3:0]       r_i,
  input  logic [3:0]       g_i,
  input  logic [3:0]       b_i,
  output logic [ACC_W-1:0] sum_r_o,
  output logic [ACC_W-1:0] sum_g_o,
  output logic [ACC_W-1:0] sum_b_o,
  output logic             full_o
);

  localparam logic [9:0]       WIN_X1    = WIN_X0 + 10'(WIN_SIZE - 1);
  localparam logic [9:0]       WIN_Y1    = WIN_Y0 + 10'(WIN_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WIN_SIZE * WIN_SIZE);

  logic [ACC_W-1:0] sum_r_q, sum_r_d;
  logic [ACC_W-1:0] sum_g_q, sum_g_d;
  logic [ACC_W-1:0] sum_b_q, sum_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_win;

  assign in_win = de_i && (x_i >= WIN_X0) && (x_i <= WIN_X1) &&
                  (y_i >= WIN_Y0) && (y_i <= WIN_Y1);
  assign full_o = (cnt_q == CNT_FULL);

  always_comb begin
    sum_r_d = sum_r_q;
    sum_g_d = sum_g_q;
    sum_b_d = sum_b_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      sum_r_d = '0;
      sum_g_d = '0;
      sum_b_d = '0;
      cnt_d   = '0;
    end else if (enable_i && in_win && !full_o) begin
      sum_r_d = sum_r_q + ACC_W'(r_i);
      sum_g_d = sum_g_q + ACC_W'(g_i);
      sum_b_d = sum_b_q + ACC_W'(b_i);
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r_q <= '0;
      sum_g_q <= '0;
      sum_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      sum_r_q <= sum_r_d;
      sum_g_q <= sum_g_d;
      sum_b_q <= sum_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum_r_o = sum_r_q;
  assign sum_g_o = sum_g_q;
  assign sum_b_o = sum_b_q;

endmodule

// File: rtl/chroma_calib_ctrl.sv
// Key-colour calibration FSM plus shadowed threshold registers for the chroma keyer.
// Thresholds only ever move on a start-of-frame strobe, so a frame never sees mixed settings.
module chroma_calib_ctrl
  import chroma_pkg::*;
#(
  parameter logic [9:0] WIN_X0      = 10'd312,
  parameter logic [9:0] WIN_Y0      = 10'd232,
  parameter int         G_MARGIN    = 2,
  parameter int         DIFF_MARGIN = 1,
  parameter int         MIN_G       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_red,
  input  logic [3:0] i_green,
  input  logic [3:0] i_blue,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       DE,
  input  logic       calib_req,
  input  logic       cfg_wr,
  input  logic [3:0] cfg_g,
  input  logic [3:0] cfg_diff,
  output logic [3:0] g_threshold,
  output logic [3:0] diff_threshold,
  output logic [3:0] key_r,
  output logic [3:0] key_g,
  output logic [3:0] key_b,
  output logic       key_valid,
  output logic       busy,
  output logic       calib_done,
  output logic       calib_fail,
  output logic [1:0] dbg_state
);

  localparam logic signed [5:0] G_MARGIN_S    = 6'(G_MARGIN);
  localparam logic signed [5:0] DIFF_MARGIN_S = 6'(DIFF_MARGIN);
  localparam logic signed [5:0] MIN_G_S       = 6'(MIN_G);

  calib_state_e     state_q, state_d;
  logic [3:0]       g_act_q, g_act_d, diff_act_q, diff_act_d;
  logic [3:0]       shadow_g_q, shadow_g_d, shadow_diff_q, shadow_diff_d;
  logic             pending_q, pending_d;
  logic [3:0]       key_r_q, key_r_d, key_g_q, key_g_d, key_b_q, key_b_d;
  logic             key_valid_q, key_valid_d;
  logic             done_q, done_d, fail_q, fail_d;
  logic             sof, acc_clear, acc_full;
  logic [ACC_W-1:0] sum_r, sum_g, sum_b;
  logic [3:0]       avg_r, avg_g, avg_b;
  logic signed [5:0] dr, db, m, g_sub;
  logic [3:0]       g_new, diff_new;
  logic             unused_sum_lsbs;

  assign sof = DE && (x_pixel == 10'd0) && (y_pixel == 10'd0);

  chroma_win_accum #(
    .WIN_X0 (WIN_X0),
    .WIN_Y0 (WIN_Y0)
  ) u_accum (
    .clk      (clk),
    .rst_n    (reset),
    .clear_i  (acc_clear),
    .enable_i (state_q == ACCUM),
    .de_i     (DE),
    .x_i      (x_pixel),
    .y_i      (y_pixel),
    .r_i      (i_red),
    .g_i      (i_green),
    .b_i      (i_blue),
    .sum_r_o  (sum_r),
    .sum_g_o  (sum_g),
    .sum_b_o  (sum_b),
    .full_o   (acc_full)
  );

  // Dividing by the 256 samples is just taking the top nibble of each sum.
  assign avg_r = sum_r[ACC_W-1:2*WIN_LOG2];
  assign avg_g = sum_g[ACC_W-1:2*WIN_LOG2];
  assign avg_b = sum_b[ACC_W-1:2*WIN_LOG2];
  assign unused_sum_lsbs = ^{sum_r[2*WIN_LOG2-1:0], sum_g[2*WIN_LOG2-1:0], sum_b[2*WIN_LOG2-1:0]};

  assign dr       = $signed({2'b00, avg_g}) - $signed({2'b00, avg_r});
  assign db       = $signed({2'b00, avg_g}) - $signed({2'b00, avg_b});
  assign m        = (dr < db) ? dr : db;
  assign g_sub    = $signed({2'b00, avg_g}) - G_MARGIN_S;
  assign g_new    = (g_sub < MIN_G_S) ? MIN_G_S[3:0] : g_sub[3:0];
  assign diff_new = m[3:0] - DIFF_MARGIN_S[3:0];

  always_comb begin
    state_d       = state_q;
    g_act_d       = g_act_q;
    diff_act_d    = diff_act_q;
    shadow_g_d    = shadow_g_q;
    shadow_diff_d = shadow_diff_q;
    pending_d     = pending_q;
    key_r_d       = key_r_q;
    key_g_d       = key_g_q;
    key_b_d       = key_b_q;
    key_valid_d   = key_valid_q;
    done_d        = 1'b0;
    fail_d        = 1'b0;
    acc_clear     = 1'b0;

    if (sof && pending_q) begin
      g_act_d    = shadow_g_q;
      diff_act_d = shadow_diff_q;
      pending_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cfg_wr) begin
          shadow_g_d    = cfg_g;
          shadow_diff_d = cfg_diff;
          pending_d     = 1'b1;
        end
        if (calib_req) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (sof) begin
          acc_clear = 1'b1;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        // A second SOF before the window filled means the window was never fully visible.
        if (acc_full) begin
          state_d = COMPUTE;
        end else if (sof) begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end
      end
      COMPUTE: begin
        state_d = IDLE;
        if (m <= DIFF_MARGIN_S) begin
          fail_d = 1'b1;
        end else begin
          shadow_g_d    = g_new;
          shadow_diff_d = diff_new;
          key_r_d       = avg_r;
          key_g_d       = avg_g;
          key_b_d       = avg_b;
          key_valid_d   = 1'b1;
          pending_d     = 1'b1;
          done_d        = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      g_act_q       <= DEF_G;
      diff_act_q    <= DEF_DIFF;
      shadow_g_q    <= DEF_G;
      shadow_diff_q <= DEF_DIFF;
      pending_q     <= 1'b0;
      key_r_q       <= '0;
      key_g_q       <= '0;
      key_b_q       <= '0;
      key_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      g_act_q       <= g_act_d;
      diff_act_q    <= diff_act_d;
      shadow_g_q    <= shadow_g_d;
      shadow_diff_q <= shadow_diff_d;
      pending_q     <= pending_d;
      key_r_q       <= key_r_d;
      key_g_q       <= key_g_d;
      key_b_q       <= key_b_d;
      key_valid_q   <= key_valid_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
    end
  end

  assign g_threshold    = g_act_q;
  assign diff_threshold = diff_act_q;
  assign key_r          = key_r_q;
  assign key_g          = key_g_q;
  assign key_b          = key_b_q;
  assign key_valid      = key_valid_q;
  assign busy           = (state_q != IDLE);
  assign calib_done     = done_q;
  assign calib_fail     = fail_q;
  assign dbg_state      = state_q;

endmodule
